wash_actuator: RTL

WASH_ACTUATOR -- requirements
Module: wash_actuator

---
 rtl/wash_actuator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wash_actuator.sv
// -----------------------------------------------------------------------------
// wash_actuator
//   Turns the washing-machine phase request into registered actuator drives.
//   A change of phase blanks the actuators for DEAD cycles before the new
//   phase takes effect. The door stays latched in every working phase and for
//   LOCK_HOLD cycles into Standby once the dead-time has elapsed.
//
// Parameters
//   DEAD      dead-time in cycles after any mode change
//   AG_ON     wash agitation motor-on cycles per stroke
//   RINSE_ON  rinse agitation motor-on cycles per stroke
//   AG_OFF    pause cycles between strokes (wash and rinse)
//   RAMP      spin cycles per duty increment
//   LOCK_HOLD standby cycles before the door unlocks
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   mode [2:0] requested phase: 0 Standby, 1 Fill, 2 Rinse, 3 Wash, 4 Spin
//              (5-7 are treated as Standby)
//   valve      water inlet valve open
//   drain      drain pump on
//   motor_en   drum motor enable
//   motor_dir  drum direction, 0 CW, 1 CCW
//   spin_pwm   motor speed PWM (Spin only)
//   door_lock  door latch engaged
// -----------------------------------------------------------------------------
module wash_actuator #(
  parameter int DEAD      = 2,
  parameter int AG_ON     = 6,
  parameter int RINSE_ON  = 4,
  parameter int AG_OFF    = 2,
  parameter int RAMP      = 4,
  parameter int LOCK_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  output logic       valve,
  output logic       drain,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       spin_pwm,
  output logic       door_lock
);

  typedef enum logic [2:0] {
    STANDBY = 3'd0,
    FILL    = 3'd1,
    RINSE   = 3'd2,
    WASH    = 3'd3,
    SPIN    = 3'd4
  } mode_e;

  // Terminal counts, 8 bits wide so every parameter up to 255 fits.
  localparam logic [7:0] DEAD_LOAD   = (DEAD == 0) ? 8'd0 : 8'(DEAD - 1);
  localparam logic [7:0] AG_ON_M1    = 8'(AG_ON - 1);
  localparam logic [7:0] RINSE_ON_M1 = 8'(RINSE_ON - 1);
  localparam logic [7:0] AG_OFF_M1   = 8'(AG_OFF - 1);
  localparam logic [7:0] RAMP_M1     = 8'(RAMP - 1);
  localparam logic [7:0] HOLD_LIM    = 8'(LOCK_HOLD);

  // Registered state
  mode_e      mode_q;
  logic [7:0] dead_q;   // remaining blanked edges after the current one
  logic [1:0] phase_q;  // agitation phase: 0 CW on, 1 off, 2 CCW on, 3 off
  logic [7:0] cnt_q;    // phase cycles / spin ramp cycles / standby hold cycles
  logic [3:0] duty_q;
  logic [3:0] pwm_q;
  logic       armed_q;  // Standby was entered from a working phase

  // Next-state and next-output values
  mode_e      mode_n;
  logic       change;
  logic       active;
  logic       armed_c;
  logic [1:0] phase_c, phase_n;
  logic [7:0] cnt_c, cnt_n;
  logic [3:0] duty_c, duty_n;
  logic [3:0] pwm_c, pwm_n;
  logic [7:0] dead_n;
  logic [7:0] on_m1, phase_m1;
  logic       valve_d, drain_d, motor_en_d, motor_dir_d, spin_pwm_d, door_lock_d;

  // NOTE: every signal written here gets a default first so no path through
  // the case statements leaves it unassigned and infers a latch.
  always_comb begin
    mode_n  = (mode > 3'd4) ? STANDBY : mode_e'(mode);
    change  = (mode_n != mode_q);

    // On a change every sequence restarts from its first position, so the
    // first active edge of the new mode always emits the opening cycle.
    phase_c = change ? 2'd0 : phase_q;
    cnt_c   = change ? 8'd0 : cnt_q;
    duty_c  = change ? 4'd0 : duty_q;
    pwm_c   = change ? 4'd0 : pwm_q;
    armed_c = change ? (mode_q != STANDBY) : armed_q;

    // The change edge itself is the first blanked edge (unless DEAD is 0).
    active  = change ? (DEAD == 0) : (dead_q == 8'd0);
    if (change)               dead_n = DEAD_LOAD;
    else if (dead_q != 8'd0)  dead_n = dead_q - 8'd1;
    else                      dead_n = 8'd0;

    phase_n     = phase_c;
    cnt_n       = cnt_c;
    duty_n      = duty_c;
    pwm_n       = pwm_c;
    on_m1       = (mode_n == WASH) ? AG_ON_M1 : RINSE_ON_M1;
    phase_m1    = phase_c[0] ? AG_OFF_M1 : on_m1;
    valve_d     = 1'b0;
    drain_d     = 1'b0;
    motor_en_d  = 1'b0;
    motor_dir_d = 1'b0;
    spin_pwm_d  = 1'b0;

    // Locked in any working phase; in Standby only while the hold runs. The
    // hold counts from the first post-dead-time edge, so the blanked edges
    // stay locked as well.
    door_lock_d = (mode_n != STANDBY) ||
                  (armed_c && (!active || (cnt_c < HOLD_LIM)));

    if (active) begin
      case (mode_n)
        FILL: valve_d = 1'b1;

        WASH, RINSE: begin
          motor_en_d  = ~phase_c[0];
          motor_dir_d = (phase_c == 2'd2);
          if (cnt_c == phase_m1) begin
            cnt_n   = 8'd0;
            phase_n = phase_c + 2'd1;
          end else begin
            cnt_n   = cnt_c + 8'd1;
          end
        end

        SPIN: begin
          drain_d    = 1'b1;
          motor_en_d = 1'b1;
          spin_pwm_d = (pwm_c < duty_c);
          pwm_n      = pwm_c + 4'd1;
          if (cnt_c == RAMP_M1) begin
            cnt_n = 8'd0;
            if (duty_c != 4'hF) duty_n = duty_c + 4'd1;
          end else begin
            cnt_n = cnt_c + 8'd1;
          end
        end

        STANDBY: begin
          if (cnt_c < HOLD_LIM) cnt_n = cnt_c + 8'd1;
        end

        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= STANDBY;
      dead_q    <= 8'd0;
      phase_q   <= 2'd0;
      cnt_q     <= 8'd0;
      duty_q    <= 4'd0;
      pwm_q     <= 4'd0;
      armed_q   <= 1'b0;
      valve     <= 1'b0;
      drain     <= 1'b0;
      motor_en  <= 1'b0;
      motor_dir <= 1'b0;
      spin_pwm  <= 1'b0;
      door_lock <= 1'b0;
    end else begin
      mode_q    <= mode_n;
      dead_q    <= dead_n;
      phase_q   <= phase_n;
      cnt_q     <= cnt_n;
      duty_q    <= duty_n;
      pwm_q     <= pwm_n;
      armed_q   <= armed_c;
      valve     <= valve_d;
      drain     <= drain_d;
      motor_en  <= motor_en_d;
      motor_dir <= motor_dir_d;
      spin_pwm  <= spin_pwm_d;
      door_lock <= door_lock_d;
    end
  end

endmodule
